// File: rtl/ingr_dest_filter_pkg.sv
// Shared types and default widths for the ingress destination filter.
package ingr_dest_filter_pkg;

  localparam int unsigned DEF_BUS_W     = 64;
  localparam int unsigned DEF_ID_W      = 4;
  localparam int unsigned DEF_NUM_DESTS = 16;
  localparam int unsigned DEF_CNT_W     = 32;

  typedef enum logic [1:0] {
    ST_SOP  = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } filt_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage valid/ready register: 1-cycle latency, full throughput,
// payload held stable while stalled.
module axis_reg_slice #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_c,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  always_comb begin
    in_ready_c = !valid_q || out_ready_i;
    load       = in_valid_i && in_ready_c;
    valid_d    = valid_q;
    data_d     = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/ingr_dest_filter.sv
// Drops whole packets whose first-beat tdest is out of range or disabled;
// forwards the rest through one register stage and counts drops.
module ingr_dest_filter
  import ingr_dest_filter_pkg::*;
#(
  parameter int unsigned AXIS_BUS_WIDTH = DEF_BUS_W,
  parameter int unsigned AXIS_ID_WIDTH  = DEF_ID_W,
  parameter int unsigned NUM_DESTS      = DEF_NUM_DESTS,
  parameter int unsigned DROP_CNT_WIDTH = DEF_CNT_W
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [AXIS_ID_WIDTH-1:0]    axis_in_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
  output logic [AXIS_ID_WIDTH-1:0]    axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0] axis_out_tkeep,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  input  logic [NUM_DESTS-1:0]        dest_enable,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count,
  output logic                        drop_pulse
);

  localparam int unsigned KEEP_W     = AXIS_BUS_WIDTH / 8;
  localparam int unsigned DEST_SPACE = 1 << AXIS_ID_WIDTH;
  localparam int unsigned SLICE_W    = AXIS_BUS_WIDTH + AXIS_ID_WIDTH + KEEP_W + 1;

  filt_state_e               state_q, state_d;
  logic [AXIS_ID_WIDTH-1:0]  tdest_q, tdest_d;
  logic [DROP_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      pulse_q;

  logic [DEST_SPACE-1:0]     en_pad;
  logic                      in_range;
  logic                      dest_ok_c;
  logic                      drop_evt_c;
  logic                      slice_valid_c;
  logic                      slice_ready_c;
  logic [SLICE_W-1:0]        slice_in;
  logic [SLICE_W-1:0]        slice_out;

  // Mask padded to the full tdest space so any tdest indexes it safely.
  assign en_pad    = DEST_SPACE'(dest_enable);
  assign in_range  = 32'(axis_in_tdest) < NUM_DESTS;
  assign dest_ok_c = in_range && en_pad[axis_in_tdest];

  always_comb begin
    state_d        = state_q;
    tdest_d        = tdest_q;
    cnt_d          = cnt_q;
    slice_valid_c  = 1'b0;
    axis_in_tready = 1'b0;
    drop_evt_c     = 1'b0;
    unique case (state_q)
      ST_SOP: begin
        if (dest_ok_c) begin
          slice_valid_c  = axis_in_tvalid;
          axis_in_tready = slice_ready_c;
          if (axis_in_tvalid && slice_ready_c) begin
            tdest_d = axis_in_tdest;
            if (!axis_in_tlast) state_d = ST_PASS;
          end
        end else begin
          // Rejected first beats never wait on a stalled output register.
          axis_in_tready = 1'b1;
          drop_evt_c     = axis_in_tvalid;
          if (axis_in_tvalid && !axis_in_tlast) state_d = ST_DROP;
        end
      end
      ST_PASS: begin
        slice_valid_c  = axis_in_tvalid;
        axis_in_tready = slice_ready_c;
        if (axis_in_tvalid && slice_ready_c && axis_in_tlast) state_d = ST_SOP;
      end
      ST_DROP: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid && axis_in_tlast) state_d = ST_SOP;
      end
      default: state_d = ST_SOP;
    endcase
    if (drop_evt_c && !(&cnt_q)) cnt_d = cnt_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_SOP;
      tdest_q <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tdest_q <= tdest_d;
      cnt_q   <= cnt_d;
      pulse_q <= drop_evt_c;
    end
  end

  assign slice_in = {axis_in_tdata, tdest_d, axis_in_tkeep, axis_in_tlast};

  axis_reg_slice #(
    .DATA_W (SLICE_W)
  ) u_slice (
    .clk         (aclk),
    .rst_n       (aresetn),
    .in_valid_i  (slice_valid_c),
    .in_data_i   (slice_in),
    .in_ready_c  (slice_ready_c),
    .out_valid_o (axis_out_tvalid),
    .out_data_o  (slice_out),
    .out_ready_i (axis_out_tready)
  );

  assign {axis_out_tdata, axis_out_tdest, axis_out_tkeep, axis_out_tlast} = slice_out;
  assign drop_count = cnt_q;
  assign drop_pulse = pulse_q;

endmodule

// File: tb/tb_ingr_dest_filter.sv
// Directed bench for ingr_dest_filter (NUM_DESTS=10, DROP_CNT_WIDTH=4).
module tb_ingr_dest_filter;

  logic        aclk;
  logic        aresetn;
  logic [63:0] in_tdata;
  logic [3:0]  in_tdest;
  logic [7:0]  in_tkeep;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
  logic [63:0] out_tdata;
  logic [3:0]  out_tdest;
  logic [7:0]  out_tkeep;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;
  logic [9:0]  dest_enable;
  logic [3:0]  drop_count;
  logic        drop_pulse;

  int n_cmp;
  int n_err;
  logic [63:0] rx_q[$];

  ingr_dest_filter #(
    .AXIS_BUS_WIDTH (64),
    .AXIS_ID_WIDTH  (4),
    .NUM_DESTS      (10),
    .DROP_CNT_WIDTH (4)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .axis_in_tdata   (in_tdata),
    .axis_in_tdest   (in_tdest),
    .axis_in_tkeep   (in_tkeep),
    .axis_in_tlast   (in_tlast),
    .axis_in_tvalid  (in_tvalid),
    .axis_in_tready  (in_tready),
    .axis_out_tdata  (out_tdata),
    .axis_out_tdest  (out_tdest),
    .axis_out_tkeep  (out_tkeep),
    .axis_out_tlast  (out_tlast),
    .axis_out_tvalid (out_tvalid),
    .axis_out_tready (out_tready),
    .dest_enable     (dest_enable),
    .drop_count      (drop_count),
    .drop_pulse      (drop_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Records every beat that completes on the output interface.
  always @(negedge aclk)
    if (aresetn && out_tvalid && out_tready) rx_q.push_back(out_tdata);

  typedef struct {
    logic        vld;
    logic [3:0]  dest;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        ordy;
    logic [9:0]  en;
    logic        x_irdy;
    logic        x_ovld;
    logic [63:0] x_data;
    logic [3:0]  x_dest;
    logic [7:0]  x_keep;
    logic        x_last;
    logic        x_pulse;
    logic [3:0]  x_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [63:0] data,
                       input logic [7:0] k, input logic l, input logic ordy,
                       input logic [9:0] en);
    in_tvalid   = v;
    in_tdest    = d;
    in_tdata    = data;
    in_tkeep    = k;
    in_tlast    = l;
    out_tready  = ordy;
    dest_enable = en;
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  function automatic vec_t mk(logic vld, logic [3:0] dest, logic [63:0] data, logic [7:0] keep,
                              logic last, logic [9:0] en, logic x_irdy, logic x_ovld,
                              logic [3:0] x_dest, logic x_pulse, logic [3:0] x_cnt);
    vec_t v;
    v.vld = vld; v.dest = dest; v.data = data; v.keep = keep; v.last = last;
    v.ordy = 1'b1; v.en = en; v.x_irdy = x_irdy; v.x_ovld = x_ovld;
    v.x_data = data; v.x_dest = x_dest; v.x_keep = keep; v.x_last = last;
    v.x_pulse = x_pulse; v.x_cnt = x_cnt;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    aresetn = 1'b0;
    drive(1'b0, 4'd0, 64'd0, 8'h00, 1'b0, 1'b1, 10'h3FF);
    tick;
    tick;
    chk("rst_ovld", 64'(out_tvalid), 64'd0);
    chk("rst_odata", out_tdata, 64'd0);
    chk("rst_odest", 64'(out_tdest), 64'd0);
    chk("rst_olast", 64'(out_tlast), 64'd0);
    chk("rst_cnt", 64'(drop_count), 64'd0);
    chk("rst_pulse", 64'(drop_pulse), 64'd0);
    aresetn = 1'b1;
    tick;

    // 3-beat tdest=2 packet, per-beat tdest on beat 2 ignored
    tbl.push_back(mk(1, 4'd2, 64'hA1, 8'hFF, 0, 10'h3FF, 1, 1, 4'd2, 0, 4'd0));
    tbl.push_back(mk(1, 4'd7, 64'hA2, 8'hFF, 0, 10'h3FF, 1, 1, 4'd2, 0, 4'd0));
    tbl.push_back(mk(1, 4'd2, 64'hA3, 8'h0F, 1, 10'h3FF, 1, 1, 4'd2, 0, 4'd0));
    // 4-beat packet to disabled dest 5
    tbl.push_back(mk(1, 4'd5, 64'hB1, 8'hFF, 0, 10'h3DF, 1, 0, 4'd0, 1, 4'd1));
    tbl.push_back(mk(1, 4'd5, 64'hB2, 8'hFF, 0, 10'h3DF, 1, 0, 4'd0, 0, 4'd1));
    tbl.push_back(mk(1, 4'd5, 64'hB3, 8'hFF, 0, 10'h3DF, 1, 0, 4'd0, 0, 4'd1));
    tbl.push_back(mk(1, 4'd5, 64'hB4, 8'h0F, 1, 10'h3DF, 1, 0, 4'd0, 0, 4'd1));
    // out-of-range single beat, then in-range single beat with no bubble
    tbl.push_back(mk(1, 4'd12, 64'hC1, 8'h0F, 1, 10'h3FF, 1, 0, 4'd0, 1, 4'd2));
    tbl.push_back(mk(1, 4'd3, 64'hD1, 8'h0F, 1, 10'h3FF, 1, 1, 4'd3, 0, 4'd2));
    // enable cleared mid-packet, next packet to same dest dropped
    tbl.push_back(mk(1, 4'd2, 64'hE1, 8'hFF, 0, 10'h3FF, 1, 1, 4'd2, 0, 4'd2));
    tbl.push_back(mk(1, 4'd2, 64'hE2, 8'hFF, 0, 10'h3FB, 1, 1, 4'd2, 0, 4'd2));
    tbl.push_back(mk(1, 4'd2, 64'hE3, 8'h0F, 1, 10'h3FB, 1, 1, 4'd2, 0, 4'd2));
    tbl.push_back(mk(1, 4'd2, 64'hF1, 8'h0F, 1, 10'h3FB, 1, 0, 4'd0, 1, 4'd3));
    tbl.push_back(mk(0, 4'd0, 64'h00, 8'h00, 0, 10'h3FF, 1, 0, 4'd0, 0, 4'd3));

    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].dest, tbl[i].data, tbl[i].keep, tbl[i].last,
            tbl[i].ordy, tbl[i].en);
      #1;
      chk($sformatf("v%0d_irdy", i), 64'(in_tready), 64'(tbl[i].x_irdy));
      tick;
      chk($sformatf("v%0d_ovld", i), 64'(out_tvalid), 64'(tbl[i].x_ovld));
      chk($sformatf("v%0d_pulse", i), 64'(drop_pulse), 64'(tbl[i].x_pulse));
      chk($sformatf("v%0d_cnt", i), 64'(drop_count), 64'(tbl[i].x_cnt));
      if (tbl[i].x_ovld) begin
        chk($sformatf("v%0d_data", i), out_tdata, tbl[i].x_data);
        chk($sformatf("v%0d_dest", i), 64'(out_tdest), 64'(tbl[i].x_dest));
        chk($sformatf("v%0d_keep", i), 64'(out_tkeep), 64'(tbl[i].x_keep));
        chk($sformatf("v%0d_last", i), 64'(out_tlast), 64'(tbl[i].x_last));
      end
    end

    // Downstream stall for 5 cycles after the first beat is buffered
    rx_q.delete();
    drive(1, 4'd4, 64'h60, 8'hFF, 0, 1'b0, 10'h3FF);
    #1;
    chk("stall_irdy0", 64'(in_tready), 64'd1);
    tick;
    drive(1, 4'd4, 64'h61, 8'hFF, 0, 1'b0, 10'h3FF);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_irdy", c), 64'(in_tready), 64'd0);
      tick;
      chk($sformatf("stall%0d_ovld", c), 64'(out_tvalid), 64'd1);
      chk($sformatf("stall%0d_data", c), out_tdata, 64'h60);
    end
    out_tready = 1'b1;
    #1;
    chk("stall_release_irdy", 64'(in_tready), 64'd1);
    tick;
    drive(1, 4'd9, 64'h62, 8'hFF, 0, 1'b1, 10'h3FF);
    tick;
    drive(1, 4'd9, 64'h63, 8'h0F, 1, 1'b1, 10'h3FF);
    tick;
    drive(0, 4'd0, 64'h0, 8'h00, 0, 1'b1, 10'h3FF);
    tick;
    tick;
    chk("stall_rx_count", 64'(rx_q.size()), 64'd4);
    for (int b = 0; b < 4 && b < rx_q.size(); b++)
      chk($sformatf("stall_rx%0d", b), rx_q[b], 64'h60 + 64'(b));

    // Saturate the 4-bit drop counter with out-of-range single beats
    for (int d = 0; d < 13; d++) begin
      drive(1, 4'd15, 64'hD0 + 64'(d), 8'h0F, 1, 1'b1, 10'h3FF);
      tick;
      chk($sformatf("sat%0d_pulse", d), 64'(drop_pulse), 64'd1);
      chk($sformatf("sat%0d_cnt", d), 64'(drop_count), (d < 12) ? 64'(4 + d) : 64'hF);
    end

    // Reset mid-packet, remainder treated as a fresh packet
    drive(1, 4'd1, 64'h77, 8'hFF, 0, 1'b1, 10'h3FF);
    tick;
    chk("prerst_ovld", 64'(out_tvalid), 64'd1);
    drive(0, 4'd0, 64'h0, 8'h00, 0, 1'b1, 10'h3FF);
    aresetn = 1'b0;
    #1;
    chk("midrst_ovld", 64'(out_tvalid), 64'd0);
    chk("midrst_odata", out_tdata, 64'd0);
    chk("midrst_odest", 64'(out_tdest), 64'd0);
    chk("midrst_cnt", 64'(drop_count), 64'd0);
    chk("midrst_pulse", 64'(drop_pulse), 64'd0);
    tick;
    aresetn = 1'b1;
    drive(1, 4'd6, 64'h78, 8'h0F, 1, 1'b1, 10'h3FF);
    #1;
    chk("postrst_irdy", 64'(in_tready), 64'd1);
    tick;
    chk("postrst_ovld", 64'(out_tvalid), 64'd1);
    chk("postrst_data", out_tdata, 64'h78);
    chk("postrst_dest", 64'(out_tdest), 64'd6);
    chk("postrst_cnt", 64'(drop_count), 64'd0);
    drive(0, 4'd0, 64'h0, 8'h00, 0, 1'b1, 10'h3FF);
    tick;
    chk("postrst_idle", 64'(out_tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
